// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier {sign, exp, frac}, denormals flushed to zero.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; without it the fraction is truncated.
module fp_mul_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+FRAC_W:0] arg_0,
    input  logic [EXP_W+FRAC_W:0] arg_1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+FRAC_W:0] ret_0
);
    localparam int unsigned MW = FRAC_W + 1;
    localparam int unsigned PW = 2 * MW;
    localparam int unsigned XW = EXP_W + 2;
    localparam logic [XW-1:0] BIAS = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S0: unpack and mantissa multiply
    logic [EXP_W-1:0] ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic [MW-1:0] ma, mb;
    logic sign0_d, zero0_d, inf0_d;
    logic [PW-1:0] prod0_d;

    always_comb begin
        ea      = arg_0[FRAC_W +: EXP_W];
        eb      = arg_1[FRAC_W +: EXP_W];
        fa      = arg_0[FRAC_W-1:0];
        fb      = arg_1[FRAC_W-1:0];
        ma      = {|ea, fa};
        mb      = {|eb, fb};
        sign0_d = arg_0[EXP_W+FRAC_W] ^ arg_1[EXP_W+FRAC_W];
        zero0_d = (ea == '0) | (eb == '0);
        inf0_d  = (ea == '1) | (eb == '1);
        prod0_d = {{MW{1'b0}}, ma} * {{MW{1'b0}}, mb};
    end

    logic v0_q, sign0_q, zero0_q, inf0_q;
    logic [EXP_W-1:0] ea0_q, eb0_q;
    logic [PW-1:0] prod0_q;

    // S1: normalise, exponent sum, optional rounding
    logic c1;
    logic [PW-2:0] norm;
    logic [FRAC_W-1:0] frac_raw, frac1_d;
    logic [XW-1:0] exp_sum, exp1_d;

    always_comb begin
        c1       = prod0_q[PW-1];
        // Left-align so the bit below the leading one is always at the top of norm
        norm     = c1 ? prod0_q[PW-2:0] : {prod0_q[PW-3:0], 1'b0};
        frac_raw = norm[PW-2 -: FRAC_W];
        exp_sum  = {2'b00, ea0_q} + {2'b00, eb0_q} - BIAS + {{(XW-1){1'b0}}, c1};
    end

`ifdef FP_MUL_ROUND_EN
    logic guard, sticky, round_up, carry;
    always_comb begin
        guard             = norm[FRAC_W];
        sticky            = |norm[FRAC_W-1:0];
        round_up          = guard & (sticky | frac_raw[0]);
        {carry, frac1_d}  = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};
        exp1_d            = exp_sum + {{(XW-1){1'b0}}, carry};
    end
`else
    logic unused_norm_lsbs;
    assign unused_norm_lsbs = ^norm[FRAC_W:0];
    assign frac1_d          = frac_raw;
    assign exp1_d           = exp_sum;
`endif

    logic v1_q, sign1_q, zero1_q, inf1_q;
    logic [XW-1:0] exp1_q;
    logic [FRAC_W-1:0] frac1_q;

    // S2: special-case select; zero wins over infinity
    logic under, over;
    logic [EXP_W+FRAC_W:0] ret_d;

    always_comb begin
        under = exp1_q[XW-1] | (exp1_q == '0);
        over  = ~exp1_q[XW-1] & (exp1_q[EXP_W:0] >= EMAX);
        if (zero1_q | under) begin
            ret_d = {sign1_q, {(EXP_W + FRAC_W){1'b0}}};
        end else if (inf1_q | over) begin
            ret_d = {sign1_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            ret_d = {sign1_q, exp1_q[EXP_W-1:0], frac1_q};
        end
    end

    logic v2_q;
    logic [EXP_W+FRAC_W:0] ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q  <= 1'b0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ret_q <= '0;
        end else if (!stall) begin
            v0_q  <= in_valid;
            v1_q  <= v0_q;
            v2_q  <= v1_q;
            ret_q <= ret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            sign0_q <= sign0_d;
            zero0_q <= zero0_d;
            inf0_q  <= inf0_d;
            ea0_q   <= ea;
            eb0_q   <= eb;
            prod0_q <= prod0_d;
            sign1_q <= sign0_q;
            zero1_q <= zero0_q;
            inf1_q  <= inf0_q;
            exp1_q  <= exp1_d;
            frac1_q <= frac1_d;
        end
    end

    assign out_valid = v2_q;
    assign ret_0     = ret_q;

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter FRAC_W, default 7, stored fraction width; defaults give bfloat16; W = 1+EXP_W+FRAC_W.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port arg_0  input  W  operand A {sign, exp, frac}.
REQ-008 SHALL have port arg_1  input  W  operand B {sign, exp, frac}.
REQ-009 SHALL have port out_valid  output  1  ret_0 holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port ret_0  output  W  product {sign, exp, frac}.

Function
REQ-012 SHALL implement a 3-stage pipeline: S0 unpack, sign XOR, (FRAC_W+1)x(FRAC_W+1) mantissa multiply; S1 normalise, exponent sum, optional round; S2 special-case select, output register.
REQ-013 SHALL use one global stall: stall = out_valid & !out_ready; in_ready = !stall; when stall, no stage register or valid bit changes.
REQ-014 SHALL give latency exactly 3 cycles from accepting handshake (in_valid & in_ready) to out_valid with no stall; throughput 1 result/cycle.
REQ-015 SHALL keep results in acceptance order; no drop or duplicate under any out_ready pattern.
REQ-016 SHALL hold ret_0 stable while out_valid & !out_ready.
REQ-017 SHALL treat exponent 0 input as zero (denormals flushed), hidden bit 1 otherwise.
REQ-018 SHALL compute exponent in EXP_W+2-bit signed arithmetic: e = eA + eB - BIAS + c, BIAS = 2^(EXP_W-1)-1, c = product MSB (product in [2,4)).
REQ-019 SHALL select fraction as product bits below the leading one, shifted by c, FRAC_W bits kept.
REQ-020 SHALL, after any rounding carry, output signed zero (exp 0, frac 0) when either input exponent is 0 or e <= 0.
REQ-021 SHALL output signed infinity (exp all-ones, frac 0) when neither input is zero and (either input exponent all-ones or e >= 2^EXP_W-1).
REQ-022 SHALL give zero precedence over infinity; NaN never generated; sign always sA ^ sB.

Reset
REQ-023 SHALL, on rst high at a clock edge, clear all stage valid bits; out_valid = 0 and ret_0 = 0 the following cycle.
REQ-024 SHALL discard in-flight operations on reset mid-operation; in_ready = 1 the cycle after reset.
REQ-025 SHALL ignore in_valid during a cycle with rst high.

Configuration
REQ-026 SHALL, with macro FP_MUL_ROUND_EN defined, round fraction to nearest-even using guard and sticky bits of the full product; a rounding carry out of the fraction increments e before REQ-020/021 checks.
REQ-027 SHALL, without FP_MUL_ROUND_EN, truncate the fraction (no rounding logic synthesised).

Verification
REQ-028 SHALL check 0x3FC0 x 0x3FC0 (1.5x1.5) -> 0x4010 three cycles later, out_ready high.
REQ-029 SHALL check 0xC000 x 0x4040 (-2x3) -> 0xC0C0; 0x7F00 x 0x4000 -> 0x7F80; 0x0080 x 0x3F00 -> 0x0000; 0x8000 x 0x7F80 -> 0x8000.
REQ-030 SHALL check 0x3FC1 x 0x3FC1 -> 0x4011 without FP_MUL_ROUND_EN, 0x4012 with it.
REQ-031 SHALL check backpressure: 5 back-to-back inputs, out_ready low 4 cycles after first out_valid -> in_ready low while stalled, ret_0 stable, all 5 results in order, none lost.
REQ-032 SHALL check reset mid-operation: 2 operations accepted, rst high 1 cycle -> out_valid 0 next cycle, neither result ever emitted, next input's result 3 cycles after acceptance.
REQ-033 SHALL check random stream (EXP_W=8, FRAC_W=23 and defaults) with random out_ready against reference model -> bit-exact, ordered.
